// File: rtl/uart_rx_pkg.sv
// Shared UART RX types: FSM state encoding and data-width limits.
// Used by the RX deserializer, the RX FSM and the bit sampler.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } uart_rx_state_e;

    localparam int unsigned UART_MAX_DATA_WIDTH = 16;

endpackage

// File: rtl/uart_rx_deser_frame.sv
// UART RX deserializer: shifts sampled bits into a word and commits it to a valid/ready
// holding register with sticky overrun. Parity check enabled by UART_RX_PARITY_CHK_EN.
module uart_rx_deser_frame
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  deser_start,
    input  logic                  deser_edge_done,
    input  logic                  deser_sampled_bit,
    input  logic                  deser_msb_first,
    input  logic                  deser_data_ready,
    output logic [DATA_WIDTH-1:0] deser_p_data,
    output logic                  deser_data_valid,
    output logic                  deser_busy,
    output logic                  deser_overrun,
    output logic                  deser_par_err,
    input  logic                  deser_par_odd
);

    localparam int unsigned CNT_WIDTH = $clog2(DATA_WIDTH + 2);
    localparam logic [CNT_WIDTH-1:0] LastData = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] One = CNT_WIDTH'(1);

    uart_rx_state_e        state_q, state_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d, sr_shift;
    logic                  msb_q, msb_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ovr_q, ovr_d;
    logic                  fire, commit;

`ifdef UART_RX_PARITY_CHK_EN
    localparam logic [CNT_WIDTH-1:0] LastPar = CNT_WIDTH'(DATA_WIDTH + 1);
    logic pbit_q, pbit_d;
    logic perr_q, perr_d;
`else
    logic unused_par_odd;
    assign unused_par_odd = deser_par_odd;
`endif

    assign sr_shift = msb_q ? {sr_q[DATA_WIDTH-2:0], deser_sampled_bit}
                            : {deser_sampled_bit, sr_q[DATA_WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sr_d    = sr_q;
        msb_d   = msb_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
`ifdef UART_RX_PARITY_CHK_EN
        pbit_d  = pbit_q;
        perr_d  = perr_q;
`endif
        commit  = 1'b0;
        fire    = valid_q && deser_data_ready;

        unique case (state_q)
            IDLE: state_d = IDLE;
            SHIFT: begin
`ifdef UART_RX_PARITY_CHK_EN
                if (deser_edge_done) begin
                    sr_d    = sr_shift;
                    count_d = count_q + One;
                    if (count_q == LastData - One) state_d = PARITY;
                end
`else
                // Full word sits in sr_q for one cycle before the commit.
                if (count_q == LastData) begin
                    commit = 1'b1;
                end else if (deser_edge_done) begin
                    sr_d    = sr_shift;
                    count_d = count_q + One;
                end
`endif
            end
            PARITY: begin
`ifdef UART_RX_PARITY_CHK_EN
                if (count_q == LastPar) begin
                    commit = 1'b1;
                end else if (deser_edge_done) begin
                    pbit_d  = deser_sampled_bit;
                    count_d = count_q + One;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        if (commit) state_d = IDLE;

        // A new start bit always wins; any partial frame is dropped.
        if (deser_start) begin
            state_d = SHIFT;
            count_d = '0;
            sr_d    = '0;
            msb_d   = deser_msb_first;
        end

        if (fire) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (commit) begin
            if (!valid_q || fire) begin
                data_d  = sr_q;
                valid_d = 1'b1;
`ifdef UART_RX_PARITY_CHK_EN
                perr_d  = ((^sr_q) ^ pbit_q) != deser_par_odd;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            sr_q    <= '0;
            msb_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_CHK_EN
            pbit_q  <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sr_q    <= sr_d;
            msb_q   <= msb_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_CHK_EN
            pbit_q  <= pbit_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign deser_p_data     = data_q;
    assign deser_data_valid = valid_q;
    assign deser_busy       = (state_q != IDLE);
    assign deser_overrun    = ovr_q;
`ifdef UART_RX_PARITY_CHK_EN
    assign deser_par_err    = perr_q;
`else
    assign deser_par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deser_frame.sv
// Bench for uart_rx_deser_frame: directed scenarios plus randomized frames, checked every
// cycle against a frame-level reference model. Honours UART_RX_PARITY_CHK_EN.
module tb_uart_rx_deser_frame;

    localparam int W = 8;
`ifdef UART_RX_PARITY_CHK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NBITS = W + (PAR ? 1 : 0);

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         deser_start = 1'b0;
    logic         deser_edge_done = 1'b0;
    logic         deser_sampled_bit = 1'b0;
    logic         deser_msb_first = 1'b0;
    logic         deser_data_ready = 1'b0;
    logic         deser_par_odd = 1'b0;
    logic [W-1:0] deser_p_data;
    logic         deser_data_valid;
    logic         deser_busy;
    logic         deser_overrun;
    logic         deser_par_err;

    always #5 clk = ~clk;

    uart_rx_deser_frame #(.DATA_WIDTH(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .deser_start       (deser_start),
        .deser_edge_done   (deser_edge_done),
        .deser_sampled_bit (deser_sampled_bit),
        .deser_msb_first   (deser_msb_first),
        .deser_data_ready  (deser_data_ready),
        .deser_p_data      (deser_p_data),
        .deser_data_valid  (deser_data_valid),
        .deser_busy        (deser_busy),
        .deser_overrun     (deser_overrun),
        .deser_par_err     (deser_par_err),
        .deser_par_odd     (deser_par_odd)
    );

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    bit rand_ready = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: collects a frame's bits in a queue, assembles the word once complete.
    bit           m_active, m_pending, m_msb;
    bit           m_bits[$];
    logic [W-1:0] m_data;
    bit           m_valid, m_ovr, m_perr;

    always @(posedge clk) begin : model
        bit           fire, commit, old_valid, pbit;
        logic [W-1:0] word;
        if (!rst) begin
            m_active = 0; m_pending = 0; m_bits.delete();
            m_data = '0; m_valid = 0; m_ovr = 0; m_perr = 0;
        end else begin
            fire      = m_valid && deser_data_ready;
            commit    = m_pending;
            old_valid = m_valid;
            word      = '0;
            pbit      = 1'b0;
            if (commit) begin
                for (int i = 0; i < W; i++) word[m_msb ? W - 1 - i : i] = m_bits[i];
                if (PAR) pbit = m_bits[W];
                m_pending = 0;
                m_active  = 0;
            end
            if (fire) begin
                m_valid = 0;
                m_ovr   = 0;
            end
            if (commit) begin
                if (!old_valid || fire) begin
                    m_data  = word;
                    m_valid = 1;
                    m_perr  = PAR && (((^word) ^ pbit) != deser_par_odd);
                end else begin
                    m_ovr = 1;
                end
            end
            if (deser_start) begin
                m_active  = 1;
                m_pending = 0;
                m_bits.delete();
                m_msb = deser_msb_first;
            end else if (deser_edge_done && m_active && !m_pending) begin
                m_bits.push_back(deser_sampled_bit);
                if (m_bits.size() == NBITS) m_pending = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("valid", deser_data_valid, m_valid);
            check_eq("overrun", deser_overrun, m_ovr);
            check_eq("busy", deser_busy, m_active);
            check_eq("par_err", deser_par_err, m_perr);
            check_eq("p_data", deser_p_data, m_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        deser_start     = 1'b0;
        deser_edge_done = 1'b0;
        if (rand_ready) deser_data_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [16:0] frame_bits(input logic [W-1:0] word, input bit msb,
                                               input bit pbit);
        logic [16:0] b;
        b = '0;
        for (int i = 0; i < W; i++) b[i] = msb ? word[W-1-i] : word[i];
        b[W] = pbit;
        return b;
    endfunction

    // Edge pulses only; msb_first is scrambled in gaps to show it is latched at start.
    task automatic send_tail(input logic [16:0] bits, input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                deser_msb_first = 1'($urandom_range(0, 1));
                step();
            end
            deser_edge_done   = 1'b1;
            deser_sampled_bit = bits[i];
            step();
        end
    endtask

    task automatic send_bits(input logic [16:0] bits, input int n, input bit msb,
                             input int max_gap);
        deser_start     = 1'b1;
        deser_msb_first = msb;
        step();
        send_tail(bits, n, max_gap);
    endtask

    task automatic consume();
        deser_data_ready = 1'b1;
        step();
        deser_data_ready = 1'b0;
    endtask

    logic [16:0] b;

    initial begin
        step();
        step();
        chk_en = 1'b1;
        check_eq("rst_valid", deser_data_valid, 0);
        check_eq("rst_busy", deser_busy, 0);
        check_eq("rst_data", deser_p_data, 0);
        check_eq("rst_ovr", deser_overrun, 0);
        rst = 1'b1;
        step();

        // 1: LSB-first 1,1,0,1,1,1,1,0 -> 7B, valid one clock after the last bit
        b = 17'b0_0111_1011;
        send_bits(b, NBITS, 1'b0, 0);
        check_eq("t1_valid_early", deser_data_valid, 0);
        step();
        check_eq("t1_valid", deser_data_valid, 1);
        check_eq("t1_data", deser_p_data, 8'h7B);
        consume();

        // 2: same stream MSB-first -> DE, msb_first wiggled mid-frame
        send_bits(b, NBITS, 1'b1, 2);
        deser_msb_first = 1'b0;
        step();
        check_eq("t2_data", deser_p_data, 8'hDE);
        check_eq("t2_valid", deser_data_valid, 1);
        consume();

        // 3: two frames without ready -> first kept, overrun set; handshake clears both
        send_bits(frame_bits(8'hA5, 1'b0, 1'b0), NBITS, 1'b0, 1);
        step(); step();
        send_bits(frame_bits(8'h3C, 1'b0, 1'b0), NBITS, 1'b0, 1);
        step(); step();
        check_eq("t3_data", deser_p_data, 8'hA5);
        check_eq("t3_ovr", deser_overrun, 1);
        check_eq("t3_valid", deser_data_valid, 1);
        consume();
        check_eq("t3_valid_clr", deser_data_valid, 0);
        check_eq("t3_ovr_clr", deser_overrun, 0);

        // 4: restart after 4 bits; start+edge_done coincident drops that bit
        b = frame_bits(8'h55, 1'b0, 1'b0);
        send_bits(17'h0_000F, 4, 1'b0, 0);
        deser_start       = 1'b1;
        deser_msb_first   = 1'b0;
        deser_edge_done   = 1'b1;
        deser_sampled_bit = ~b[0];
        step();
        send_tail(b, NBITS, 1);
        step();
        check_eq("t4_data", deser_p_data, 8'h55);
        check_eq("t4_valid", deser_data_valid, 1);
        check_eq("t4_ovr", deser_overrun, 0);

        // 5: reset mid-frame while a word is held
        send_bits(frame_bits(8'hC3, 1'b0, 1'b0), 3, 1'b0, 0);
        rst = 1'b0;
        step();
        check_eq("t5_valid", deser_data_valid, 0);
        check_eq("t5_data", deser_p_data, 0);
        check_eq("t5_busy", deser_busy, 0);
        check_eq("t5_ovr", deser_overrun, 0);
        rst = 1'b1;
        step();

`ifdef UART_RX_PARITY_CHK_EN
        // 6: even parity; 7B has six ones, so parity bit 0 is clean and 1 is an error
        deser_par_odd = 1'b0;
        send_bits(frame_bits(8'h7B, 1'b0, 1'b0), NBITS, 1'b0, 0);
        step();
        check_eq("t6_perr_p0", deser_par_err, 0);
        consume();
        send_bits(frame_bits(8'h7B, 1'b0, 1'b1), NBITS, 1'b0, 0);
        step();
        check_eq("t6_perr_p1", deser_par_err, 1);
        consume();
`endif

        // Randomized frames, aborts and resets against the model
        rand_ready = 1'b1;
        for (int k = 0; k < 80; k++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            deser_par_odd = 1'($urandom_range(0, 1));
            b = frame_bits(W'($urandom), 1'b0, 1'($urandom_range(0, 1)));
            if (r < 10) begin
                send_bits(b, $urandom_range(1, NBITS - 1), 1'($urandom_range(0, 1)), 2);
            end else if (r < 15) begin
                send_bits(b, $urandom_range(1, NBITS - 1), 1'($urandom_range(0, 1)), 2);
                rst = 1'b0;
                step();
                rst = 1'b1;
            end else begin
                send_bits(b, NBITS, 1'($urandom_range(0, 1)), 3);
            end
            repeat ($urandom_range(0, 3)) step();
        end
        rand_ready = 1'b0;
        deser_data_ready = 1'b1;
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
